fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Sequences instruction fetch for the pipelined core. Owns the architectural fetch PC, issues one-outstanding-request fetches to instruction memory, and presents fetched instructions to decode under a stall handshake. Applies branch-unit redirects: loads the resolved target, discards any in-flight fetch, and pulses flush to the front-end pipeline registers.

Parameters:
INSN_ADDR_WIDTH, 10, width of instruction address / PC
INSN_WIDTH, 32, instruction word width
PC_INC, 4, sequential PC increment
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_addr  out  INSN_ADDR_WIDTH  fetch address, valid while imem_req_valid
imem_rsp_valid  in  1  response data valid (at least 1 cycle after accept)
imem_rsp_insn  in  INSN_WIDTH  response instruction
fetch_valid  out  1  instruction presented to decode
fetch_pc  out  INSN_ADDR_WIDTH  PC of presented instruction
fetch_insn  out  INSN_WIDTH  presented instruction
stall  in  1  decode cannot consume this cycle
br_valid  in  1  branch resolved this cycle
br_taken  in  1  resolved branch is taken
br_target  in  INSN_ADDR_WIDTH  redirect target
flush  out  1  squash younger front-end state this cycle

Behaviour:
- Reset (rst=1 at clk edge): state=BOOT, pc=RESET_PC, drop=0, fetch_insn=0, fetch_pc=RESET_PC; imem_req_valid=0, fetch_valid=0, flush=0. Reset mid-transaction abandons any outstanding request; a late response is ignored (state is BOOT/REQ, not WAIT).
- redirect = br_valid & br_taken. br_valid & !br_taken has no effect. flush = redirect, combinational, same cycle, any non-reset state.
- BOOT: outputs idle; next state REQ. Redirect in BOOT: pc<=br_target.
- REQ: imem_req_valid=1, imem_addr=pc.
  - ready & !redirect: inflight_pc<=pc, go WAIT.
  - ready & redirect: request is consumed with the old address; drop<=1, pc<=br_target, go WAIT.
  - !ready & redirect: pc<=br_target, stay REQ; imem_addr changes next cycle (request not yet accepted, so no drop).
- WAIT: imem_req_valid=0.
  - rsp & !drop & !redirect: fetch_insn<=imem_rsp_insn, fetch_pc<=inflight_pc, pc<=inflight_pc+PC_INC (mod 2^INSN_ADDR_WIDTH), go HOLD.
  - rsp & (drop | redirect): discard data, drop<=0, go REQ (pc<=br_target if redirect).
  - !rsp & redirect: drop<=1, pc<=br_target, stay WAIT.
- HOLD: fetch_valid=1 with registered fetch_pc/fetch_insn.
  - !stall & !redirect: consumed; go REQ (next request issues the following cycle).
  - stall & !redirect: stay HOLD, outputs stable.
  - redirect (regardless of stall): held instruction squashed (downstream ignores it via flush); pc<=br_target, go REQ; fetch_valid=0 next cycle.
- Redirect has priority over every other event in every state. Only one request is ever outstanding.
- Throughput: steady state, no stall, 1-cycle memory: one instruction every 3 cycles (REQ, WAIT, HOLD).
- PC increment wraps modulo 2^INSN_ADDR_WIDTH. br_target is used unmodified (no alignment masking).

Test Plan:
- Reset release, ready=1, rsp 1 cycle after accept, stall=0 -> addrs 0,4,8 issued; fetch_valid pulses with fetch_pc 0,4,8 and matching insn.
- stall=1 for 3 cycles while in HOLD with pc 4 -> fetch_valid, fetch_pc=4, fetch_insn held stable; no imem request until stall drops.
- Redirect (target 0x40) in WAIT before rsp -> flush=1 that cycle; the arriving rsp is discarded; next request addr=0x40, next fetch_pc=0x40.
- Redirect coincident with ready in REQ at pc 8 (target 0x20) -> the response to request 8 is dropped; following request addr=0x20.
- Redirect in HOLD with stall=1 -> flush=1; fetch_valid=0 next cycle; next request addr=br_target; br_valid=1 with br_taken=0 causes no change.
- pc=0x3FC (W=10), sequential fetch -> next addr wraps to 0x000; rst asserted in WAIT -> outputs reset and the late rsp is ignored.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps a single request outstanding to
// instruction memory, holds fetched words for decode and applies branch redirects.
module fetch_redirect_ctrl #(
    parameter int unsigned                INSN_ADDR_WIDTH = 10,
    parameter int unsigned                INSN_WIDTH      = 32,
    parameter int unsigned                PC_INC          = 4,
    parameter logic [INSN_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [INSN_ADDR_WIDTH-1:0] imem_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INSN_WIDTH-1:0]      imem_rsp_insn,
    output logic                       fetch_valid,
    output logic [INSN_ADDR_WIDTH-1:0] fetch_pc,
    output logic [INSN_WIDTH-1:0]      fetch_insn,
    input  logic                       stall,
    input  logic                       br_valid,
    input  logic                       br_taken,
    input  logic [INSN_ADDR_WIDTH-1:0] br_target,
    output logic                       flush
);

    localparam logic [INSN_ADDR_WIDTH-1:0] PcInc = INSN_ADDR_WIDTH'(PC_INC);

    typedef enum logic [1:0] {StBoot, StReq, StWait, StHold} state_e;

    state_e                       state_q, state_d;
    logic [INSN_ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INSN_ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic [INSN_ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INSN_WIDTH-1:0]        fetch_insn_q, fetch_insn_d;
    logic                         drop_q, drop_d;
    logic                         redirect;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inflight_pc_d  = inflight_pc_q;
        fetch_pc_d     = fetch_pc_q;
        fetch_insn_d   = fetch_insn_q;
        drop_d         = drop_q;
        imem_req_valid = 1'b0;
        fetch_valid    = 1'b0;
        redirect       = br_valid & br_taken;
        flush          = redirect;

        unique case (state_q)
            StBoot: begin
                state_d = StReq;
                if (redirect) pc_d = br_target;
            end
            StReq: begin
                imem_req_valid = 1'b1;
                if (redirect) begin
                    pc_d = br_target;
                    // An accepted request still carries the old address; its data must be dropped.
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = StWait;
                    end
                end else if (imem_req_ready) begin
                    inflight_pc_d = pc_q;
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                        if (redirect) pc_d = br_target;
                    end else begin
                        fetch_insn_d = imem_rsp_insn;
                        fetch_pc_d   = inflight_pc_q;
                        pc_d         = inflight_pc_q + PcInc;
                        state_d      = StHold;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                    pc_d   = br_target;
                end
            end
            StHold: begin
                fetch_valid = 1'b1;
                if (redirect) begin
                    pc_d    = br_target;
                    state_d = StReq;
                end else if (!stall) begin
                    state_d = StReq;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            fetch_insn_q  <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_insn_q  <= fetch_insn_d;
            drop_q        <= drop_d;
        end
    end

    assign imem_addr  = pc_q;
    assign fetch_pc   = fetch_pc_q;
    assign fetch_insn = fetch_insn_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomised bench for fetch_redirect_ctrl: a memory responder and branch driver feed the DUT,
// a scoreboard of accepted fetches is checked against what decode is shown.
module tb_fetch_redirect_ctrl;

    localparam int unsigned   AW     = 10;
    localparam int unsigned   IW     = 32;
    localparam int unsigned   INC    = 4;
    localparam logic [AW-1:0] RST_PC = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_insn;
    logic          fetch_valid;
    logic [AW-1:0] fetch_pc;
    logic [IW-1:0] fetch_insn;
    logic          stall;
    logic          br_valid;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic          flush;

    fetch_redirect_ctrl #(
        .INSN_ADDR_WIDTH(AW),
        .INSN_WIDTH     (IW),
        .PC_INC         (INC),
        .RESET_PC       (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_insn (imem_rsp_insn),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .fetch_insn    (fetch_insn),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] insn;
    } fetch_t;

    typedef enum int {BrNone, BrAtAccept, BrInWait, BrInHold, BrNotTaken} br_req_e;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs (percentages, reset in per-mille; rsp_delay < 0 means random 0..2).
    bit            run       = 1'b0;
    int            p_ready   = 100;
    int            p_stall   = 0;
    int            p_br      = 0;
    int            p_rst     = 0;
    int            rsp_delay = 0;
    br_req_e       br_req    = BrNone;
    logic [AW-1:0] br_req_target = '0;
    bit            rst_req   = 1'b0;

    // Memory model state shared between monitor (accept detection) and driver (response).
    bit            acc_evt   = 1'b0;
    logic [AW-1:0] acc_addr  = '0;
    bit            pend      = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            rsp_cnt   = 0;
    bit            late_rsp  = 1'b0;

    // Reference model state.
    fetch_t        exp_q[$];
    fetch_t        cur;
    logic [AW-1:0] arch_pc   = RST_PC;
    bit            fv_prev   = 1'b0;
    bit            redir_prev = 1'b0;
    bit            post_rst  = 1'b0;
    bit            chk_gap   = 1'b0;
    bit            have_last = 1'b0;
    int            ncyc      = 0;
    int            last_acc  = 0;
    logic [AW-1:0] prev_acc_addr = '0;
    bit            saw_wrap  = 1'b0;

    function automatic logic [IW-1:0] insn_of(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ (32'(a) << 7) ^ 32'(a) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Driver: memory responder, handshake inputs and branch events, applied after each edge.
    always @(posedge clk) begin
        #1;
        if (run) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_insn  = $urandom;
            br_valid       = 1'b0;
            br_taken       = 1'b0;
            br_target      = AW'($urandom);
            if (rst) begin
                rst = 1'b0;
                if (late_rsp) begin
                    imem_rsp_valid = 1'b1;
                    late_rsp       = 1'b0;
                end
            end else begin
                if (acc_evt) begin
                    pend      = 1'b1;
                    pend_addr = acc_addr;
                    rsp_cnt   = (rsp_delay < 0) ? int'($urandom_range(0, 2)) : rsp_delay;
                    acc_evt   = 1'b0;
                end
                if (pend) begin
                    if (rsp_cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_insn  = insn_of(pend_addr);
                        pend           = 1'b0;
                    end else begin
                        rsp_cnt--;
                    end
                end
                imem_req_ready = ($urandom_range(0, 99) < p_ready);
                stall          = ($urandom_range(0, 99) < p_stall);
                if (br_req != BrNone) begin
                    if ((br_req == BrAtAccept && imem_req_valid && imem_req_ready) ||
                        (br_req == BrInWait && pend && !imem_rsp_valid) ||
                        (br_req == BrInHold && fetch_valid && stall)) begin
                        br_valid  = 1'b1;
                        br_taken  = 1'b1;
                        br_target = br_req_target;
                        br_req    = BrNone;
                    end else if (br_req == BrNotTaken) begin
                        br_valid = 1'b1;
                        br_req   = BrNone;
                    end
                end else if ($urandom_range(0, 99) < p_br) begin
                    br_valid = 1'b1;
                    br_taken = $urandom_range(0, 1) == 1;
                end
                if ((rst_req && pend) || ($urandom_range(0, 999) < p_rst)) begin
                    rst     = 1'b1;
                    rst_req = 1'b0;
                    if (pend) late_rsp = 1'b1;
                    pend = 1'b0;
                end
            end
        end
    end

    // Monitor: runs mid-cycle, checks outputs and advances the model past the coming edge.
    always @(negedge clk) begin
        bit redirect;
        if (rst) begin
            exp_q.delete();
            arch_pc    = RST_PC;
            fv_prev    = 1'b0;
            redir_prev = 1'b0;
            post_rst   = 1'b1;
            have_last  = 1'b0;
        end else begin
            ncyc++;
            redirect = br_valid && br_taken;
            if (post_rst) begin
                check("rst_req_valid", 64'(imem_req_valid), 64'd0);
                check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
                check("rst_fetch_pc", 64'(fetch_pc), 64'(RST_PC));
                check("rst_fetch_insn", 64'(fetch_insn), 64'd0);
                post_rst = 1'b0;
            end
            check("flush", 64'(flush), 64'(redirect));
            if (redir_prev) check("valid_after_redirect", 64'(fetch_valid), 64'd0);
            if (fetch_valid) check("req_while_holding", 64'(imem_req_valid), 64'd0);
            if (imem_req_valid) begin
                check("req_addr", 64'(imem_addr), 64'(arch_pc));
                check("one_outstanding", 64'(pend), 64'd0);
                if (imem_req_ready) begin
                    acc_evt  = 1'b1;
                    acc_addr = imem_addr;
                    if (!redirect) exp_q.push_back('{pc: imem_addr, insn: insn_of(imem_addr)});
                    if (chk_gap && have_last) check("accept_gap", 64'(ncyc - last_acc), 64'd3);
                    if (have_last && prev_acc_addr == AW'(1020) && imem_addr == '0)
                        saw_wrap = 1'b1;
                    have_last     = 1'b1;
                    last_acc      = ncyc;
                    prev_acc_addr = imem_addr;
                end
            end
            if (fetch_valid) begin
                if (!fv_prev) begin
                    check("fetch_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur     = exp_q.pop_front();
                        arch_pc = cur.pc + AW'(INC);
                    end
                end
                check("fetch_pc", 64'(fetch_pc), 64'(cur.pc));
                check("fetch_insn", 64'(fetch_insn), 64'(cur.insn));
            end
            if (redirect) begin
                arch_pc = br_target;
                exp_q.delete();
            end
            fv_prev    = fetch_valid;
            redir_prev = redirect;
        end
    end

    task automatic fire_br(input br_req_e kind, input logic [AW-1:0] tgt);
        int n = 0;
        br_req_target = tgt;
        br_req        = kind;
        while (br_req != BrNone && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("branch_event_fired", 64'(br_req == BrNone), 64'd1);
        br_req = BrNone;
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_insn  = '0;
        stall          = 1'b0;
        br_valid       = 1'b0;
        br_taken       = 1'b0;
        br_target      = '0;
        repeat (3) @(posedge clk);

        // Sequential fetch at full rate: accepts every third cycle from address 0.
        chk_gap = 1'b1;
        run     = 1'b1;
        repeat (20) @(posedge clk);
        chk_gap = 1'b0;

        // Redirect while waiting for data; the late data must be discarded.
        rsp_delay = 2;
        fire_br(BrInWait, AW'(12'h040));
        repeat (15) @(posedge clk);

        // Redirect coincident with the request being accepted.
        rsp_delay = 0;
        fire_br(BrAtAccept, AW'(12'h020));
        repeat (15) @(posedge clk);

        // Long stall in HOLD, then redirect near the top of the address space to force a wrap.
        p_stall = 100;
        repeat (10) @(posedge clk);
        fire_br(BrInHold, AW'(12'h3F8));
        p_stall = 0;
        fire_br(BrNotTaken, '0);
        repeat (20) @(posedge clk);
        check("pc_wrap_seen", 64'(saw_wrap), 64'd1);

        // Reset with a request outstanding; its response shows up after reset and is ignored.
        rsp_delay = 2;
        rst_req   = 1'b1;
        n = 0;
        while (rst_req && n < 60) begin
            @(posedge clk);
            n++;
        end
        check("reset_in_wait_fired", 64'(rst_req), 64'd0);
        rst_req = 1'b0;
        repeat (15) @(posedge clk);

        // Random traffic.
        p_ready   = 70;
        p_stall   = 40;
        p_br      = 8;
        p_rst     = 3;
        rsp_delay = -1;
        repeat (3000) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
